// File: rtl/note_sequencer.sv
// Queued tone engine: plays (note, length) requests back to back as 4-bit sine samples.
// All timing derives from clk50mhz through counter-based step enables.
module note_sequencer #(
    parameter int NUM_NOTES = 7,
    parameter int NOTE_W    = 3,
    parameter int DIV_W     = 16,
    parameter logic [NUM_NOTES*DIV_W-1:0] DIV_TABLE = {16'd2986, 16'd2660, 16'd2369, 16'd1993,
                                                       16'd1775, 16'd1582, 16'd1493},
    parameter int LEN_W     = 10,
    parameter int TICK_DIV  = 50000,
    parameter int QDEPTH    = 8
) (
    input  logic              clk50mhz,
    input  logic              reset_button,
    input  logic              note_valid,
    input  logic [NOTE_W-1:0] note_code,
    input  logic [LEN_W-1:0]  note_len,
    output logic              note_ready,
    input  logic              stop,
    output logic [3:0]        tono,
    output logic              busy,
    output logic [NOTE_W-1:0] playing_code,
    output logic              note_done,
    output logic              overflow
);
    localparam int QAW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW     = QAW + 1;
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2} state_t;

    // 32-entry sine table: round-half-up(7.5 + 7.5*sin(2*pi*k/32))
    function automatic logic [3:0] sine_rom(input logic [4:0] a);
        logic [3:0] v;
        case (a)
            5'd0:  v = 4'd8;   5'd1:  v = 4'd9;   5'd2:  v = 4'd10;  5'd3:  v = 4'd12;
            5'd4:  v = 4'd13;  5'd5:  v = 4'd14;  5'd6:  v = 4'd14;  5'd7:  v = 4'd15;
            5'd8:  v = 4'd15;  5'd9:  v = 4'd15;  5'd10: v = 4'd14;  5'd11: v = 4'd14;
            5'd12: v = 4'd13;  5'd13: v = 4'd12;  5'd14: v = 4'd10;  5'd15: v = 4'd9;
            5'd16: v = 4'd8;   5'd17: v = 4'd6;   5'd18: v = 4'd5;   5'd19: v = 4'd3;
            5'd20: v = 4'd2;   5'd21: v = 4'd1;   5'd22: v = 4'd1;   5'd23: v = 4'd0;
            5'd24: v = 4'd0;   5'd25: v = 4'd0;   5'd26: v = 4'd1;   5'd27: v = 4'd1;
            5'd28: v = 4'd2;   5'd29: v = 4'd3;   5'd30: v = 4'd5;   5'd31: v = 4'd6;
            default: v = 4'd8;
        endcase
        return v;
    endfunction

    function automatic logic code_playable(input logic [NOTE_W-1:0] code);
        return (int'(code) >= 1) && (int'(code) <= NUM_NOTES);
    endfunction

    // Divisors below 2 are raised to 2 so a step always spans at least two clocks
    function automatic logic [DIV_W-1:0] note_div(input logic [NOTE_W-1:0] code);
        logic [DIV_W-1:0] d;
        d = DIV_W'(2);
        for (int k = 1; k <= NUM_NOTES; k++) begin
            if (int'(code) == k) d = DIV_TABLE[(k-1)*DIV_W +: DIV_W];
            else                 d = d;
        end
        if (d < DIV_W'(2)) d = DIV_W'(2);
        else               d = d;
        return d;
    endfunction

    logic [NOTE_W-1:0] q_code_r [QDEPTH];
    logic [LEN_W-1:0]  q_len_r  [QDEPTH];
    logic [QAW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r, count_next_s;
    state_t            state_r, next_state_s;
    logic [NOTE_W-1:0] cur_code_r;
    logic [LEN_W-1:0]  cur_len_r, remaining_r;
    logic [DIV_W-1:0]  div_r, step_cnt_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [4:0]        addr_r;
    logic              full_s, push_s, pop_s, done_s, overflow_s, tick_end_s;
    logic [3:0]        tono_r;
    logic              note_ready_r, busy_r, note_done_r, overflow_r;
    logic [NOTE_W-1:0] playing_code_r;

    // Queue control, FSM next state and pulse generation
    always_comb begin
        full_s       = (count_r == CW'(QDEPTH));
        push_s       = note_valid && !full_s && !stop;
        overflow_s   = note_valid && full_s && !stop;
        tick_end_s   = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
        next_state_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != CW'(0)) begin
                    pop_s        = 1'b1;
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (cur_len_r == LEN_W'(0)) begin
                    done_s       = 1'b1;
                    pop_s        = (count_r != CW'(0));
                    next_state_s = pop_s ? LOAD : IDLE;
                end else begin
                    next_state_s = PLAY;
                end
            end
            PLAY: begin
                if (tick_end_s && remaining_r == LEN_W'(1)) begin
                    done_s       = 1'b1;
                    pop_s        = (count_r != CW'(0));
                    next_state_s = pop_s ? LOAD : IDLE;
                end else begin
                    next_state_s = PLAY;
                end
            end
            default: next_state_s = IDLE;
        endcase
        // A stop overrides everything, including a completion in the same cycle
        if (stop) begin
            next_state_s = IDLE;
            pop_s        = 1'b0;
            done_s       = 1'b0;
            count_next_s = CW'(0);
        end else begin
            count_next_s = count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Queue storage (contents need no reset; pointers qualify them)
    always_ff @(posedge clk50mhz) begin
        if (push_s && !reset_button) begin
            q_code_r[wr_ptr_r] <= note_code;
            q_len_r[wr_ptr_r]  <= note_len;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk50mhz) begin
        if (reset_button || stop) begin
            wr_ptr_r <= QAW'(0);
            rd_ptr_r <= QAW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + QAW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + QAW'(1);
            count_r <= count_next_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk50mhz) begin
        if (reset_button) state_r <= IDLE;
        else              state_r <= next_state_s;
    end

    // Current note capture and playback counters
    always_ff @(posedge clk50mhz) begin
        if (reset_button) begin
            cur_code_r  <= NOTE_W'(0);
            cur_len_r   <= LEN_W'(0);
            div_r       <= DIV_W'(2);
            step_cnt_r  <= DIV_W'(0);
            tick_cnt_r  <= TICK_W'(0);
            remaining_r <= LEN_W'(0);
            addr_r      <= 5'd0;
        end else begin
            if (pop_s) begin
                cur_code_r <= q_code_r[rd_ptr_r];
                cur_len_r  <= q_len_r[rd_ptr_r];
            end
            if (state_r == LOAD) begin
                div_r       <= note_div(cur_code_r);
                step_cnt_r  <= DIV_W'(0);
                tick_cnt_r  <= TICK_W'(0);
                remaining_r <= cur_len_r;
                addr_r      <= 5'd0;
            end else if (state_r == PLAY) begin
                if (step_cnt_r == div_r - DIV_W'(1)) begin
                    step_cnt_r <= DIV_W'(0);
                    addr_r     <= addr_r + 5'd1;
                end else begin
                    step_cnt_r <= step_cnt_r + DIV_W'(1);
                end
                if (tick_end_s) begin
                    tick_cnt_r  <= TICK_W'(0);
                    remaining_r <= remaining_r - LEN_W'(1);
                end else begin
                    tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk50mhz) begin
        if (reset_button) begin
            tono_r         <= 4'd8;
            note_ready_r   <= 1'b1;
            busy_r         <= 1'b0;
            playing_code_r <= NOTE_W'(0);
            note_done_r    <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            if (state_r == PLAY && code_playable(cur_code_r) && !stop) tono_r <= sine_rom(addr_r);
            else                                                       tono_r <= 4'd8;
            note_ready_r   <= (count_next_s != CW'(QDEPTH));
            busy_r         <= (next_state_s != IDLE) || (count_next_s != CW'(0));
            playing_code_r <= (next_state_s == PLAY) ? cur_code_r : NOTE_W'(0);
            note_done_r    <= done_s;
            overflow_r     <= overflow_s;
        end
    end

    assign tono         = tono_r;
    assign note_ready   = note_ready_r;
    assign busy         = busy_r;
    assign playing_code = playing_code_r;
    assign note_done    = note_done_r;
    assign overflow     = overflow_r;
endmodule
